dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (256 x 32, combinational read, write on posedge).
- Port 0 is the CPU-side data port. Port 1 is the loader/debug port.
- Each requester uses a req/ack handshake. The block grants round-robin, drives the memory control and data lines for exactly one access cycle, and returns registered read data with an ack pulse.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the data memory it fronts.
// Holds the FSM state encoding and the memory geometry.
package dmem_arbiter_pkg;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Port index helpers so the grant bit reads as a port number at call sites.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win
// last time gets the grant.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      gnt = ~last;
    end else if (req1) begin
      gnt = PORT1;
    end else begin
      gnt = PORT0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of the single-port data memory: grants
// round-robin, performs one memory access cycle, then pulses ack with registered data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = 32,
  parameter int DW    = DMEM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          arb_gnt, arb_valid;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_legal;
  logic [DW-1:0] rd_value;

  rr_arb2 u_rr_arb2 (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Granted port's request fields, valid while the grant is held.
  always_comb begin
    if (gnt_q == PORT1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
    sel_legal = ({1'b0, sel_addr} < DEPTH_W);
    rd_value  = sel_legal ? mem_rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= PORT0;
      last_q   <= PORT1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // ack/err are loaded at the ACCESS closing edge so they are high exactly in RESP.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        last_d  = gnt_q;
        state_d = ST_RESP;
        if (gnt_q == PORT1) begin
          ack1_d = 1'b1;
          err1_d = ~sel_legal;
          if (!sel_we) begin
            rdata1_d = rd_value;
          end
        end else begin
          ack0_d = 1'b1;
          err0_d = ~sel_legal;
          if (!sel_we) begin
            rdata0_d = rd_value;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write strobe is gated by reset so an aborted access never commits.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == ST_ACCESS) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      if (sel_legal) begin
        mem_write = sel_we & ~reset;
        mem_read  = ~sel_we;
      end
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver issues transactions, a monitor
// checks each ack against a sequential memory model applied in completion order.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clock = ~clock;

  logic [31:0] tb_mem [256] = '{default: 32'h0};
  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clock) if (mem_write) tb_mem[mem_addr[7:0]] <= mem_wdata;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  tx_t         stim_q [2][$];
  tx_t         exp_q  [2][$];
  int          issue_cyc [2];
  int          foreign [2];
  bit          other_act [2];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_model [2];
  int          checks = 0, errors = 0;
  int          cyc = 0, wr_cnt = 0, wr_exp = 0;
  bit          drv_en = 0, mon_en = 0, gap_en = 0;
  logic        p_mw = 0, p_mr = 0;
  logic [31:0] p_ma = 0, p_md = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? ack1 : ack0;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 1) ? err1 : err0;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  task automatic drive(input int p, input logic r, input tx_t t);
    if (p == 1) begin
      req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
    end else begin
      req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
    end
  endtask

  function automatic tx_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    tx_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // Driver: acts just after the falling edge, after the monitor has consumed acks.
  initial begin
    tx_t t;
    logic on_ack;
    forever begin
      @(negedge clock);
      #1;
      if (drv_en) begin
        for (int p = 0; p < 2; p++) begin
          on_ack = ack_of(p);
          if (exp_q[p].size() == 0) begin
            if (stim_q[p].size() > 0 && (!gap_en || $urandom_range(1, 0) == 1)) begin
              t = stim_q[p].pop_front();
              exp_q[p].push_back(t);
              issue_cyc[p] = on_ack ? cyc + 1 : cyc;
              foreign[p]   = 0;
              other_act[p] = (exp_q[1-p].size() > 0) || ack_of(1-p);
              drive(p, 1'b1, t);
            end else begin
              drive(p, 1'b0, mk(1'b0, 32'h0, 32'h0));
            end
          end
        end
      end
    end
  end

  // Monitor: reference model is a flat array updated atomically per completed transaction.
  initial begin
    tx_t  t;
    int   lat;
    logic legal;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("ack_exclusive", {31'h0, ack0 & ack1}, 32'h0);
        chk("mem_rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
        if (mem_write) wr_cnt++;
        for (int p = 0; p < 2; p++)
          if (exp_q[1-p].size() > 0 || ack_of(1-p)) other_act[p] = 1;
        for (int p = 0; p < 2; p++) begin
          if (ack_of(p)) begin
            if (exp_q[p].size() == 0) begin
              chk("ack_unexpected", 32'h1, 32'h0);
            end else begin
              t     = exp_q[p].pop_front();
              lat   = cyc - issue_cyc[p];
              legal = (t.addr < 32'd256);
              if (legal) begin
                if (t.we) begin
                  ref_mem[t.addr[7:0]] = t.wdata;
                  wr_exp++;
                end else begin
                  rd_model[p] = ref_mem[t.addr[7:0]];
                end
              end else if (!t.we) begin
                rd_model[p] = 32'h0;
              end
              chk("ack_err", {31'h0, err_of(p)}, {31'h0, ~legal});
              chk("ack_rdata", rdata_of(p), rd_model[p]);
              chk("access_write", {31'h0, p_mw}, {31'h0, legal & t.we});
              chk("access_read", {31'h0, p_mr}, {31'h0, legal & ~t.we});
              if (legal) chk("access_addr", p_ma, t.addr);
              if (legal && t.we) chk("access_wdata", p_md, t.wdata);
              if (!other_act[p]) chk("latency_solo", lat, 2);
              else chk("latency_bound", {31'h0, (lat >= 2 && lat <= 5)}, 32'h1);
              chk("fairness", {31'h0, foreign[p] <= 1}, 32'h1);
              foreign[1-p]++;
            end
          end else begin
            chk("err_quiet", {31'h0, err_of(p)}, 32'h0);
            chk("rdata_hold", rdata_of(p), rd_model[p]);
          end
        end
      end
      p_mw = mem_write; p_mr = mem_read; p_ma = mem_addr; p_md = mem_wdata;
    end
  end

  task automatic run_phase(input string name);
    int n = 0;
    while ((stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
           && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_done"}, {31'h0, n < 3000}, 32'h1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    rd_model[0] = 32'h0; rd_model[1] = 32'h0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;

    // Reset held with a pending port-0 read.
    repeat (3) begin
      @(negedge clock);
      chk("rst_ack0", {31'h0, ack0}, 32'h0);
      chk("rst_ack1", {31'h0, ack1}, 32'h0);
      chk("rst_err0", {31'h0, err0}, 32'h0);
      chk("rst_err1", {31'h0, err1}, 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("first_ack_early", {31'h0, ack0}, 32'h0);
    @(negedge clock);
    chk("first_ack", {31'h0, ack0}, 32'h1);
    chk("first_rdata", rdata0, 32'h0);
    chk("first_err", {31'h0, err0}, 32'h0);
    req0 = 1'b0;
    @(negedge clock);
    mon_en = 1; drv_en = 1;

    stim_q[0].push_back(mk(1'b1, 32'd5, 32'hDEADBEEF));
    stim_q[0].push_back(mk(1'b0, 32'd5, 32'h0));
    run_phase("write_read");

    stim_q[0].push_back(mk(1'b0, 32'd5, 32'h0));
    stim_q[0].push_back(mk(1'b1, 32'd10, 32'h0000_1010));
    stim_q[0].push_back(mk(1'b0, 32'd10, 32'h0));
    stim_q[0].push_back(mk(1'b0, 32'd11, 32'h0));
    stim_q[1].push_back(mk(1'b0, 32'd5, 32'h0));
    stim_q[1].push_back(mk(1'b1, 32'd11, 32'h0000_1111));
    stim_q[1].push_back(mk(1'b0, 32'd10, 32'h0));
    stim_q[1].push_back(mk(1'b0, 32'd11, 32'h0));
    run_phase("alternate");

    stim_q[1].push_back(mk(1'b0, 32'd256, 32'h0));
    stim_q[1].push_back(mk(1'b1, 32'd300, 32'h0000_1234));
    run_phase("illegal");
    chk("illegal_mem44", tb_mem[44], 32'h0);

    // Reset lands on the ACCESS cycle of a port-0 write.
    drv_en = 0; mon_en = 0;
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'hA5A5A5A5;
    @(negedge clock);
    chk("abort_access_write", {31'h0, mem_write}, 32'h1);
    chk("abort_access_addr", mem_addr, 32'd7);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ack_in_reset", {31'h0, ack0}, 32'h0);
    reset = 1'b0; req0 = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_ack", {31'h0, ack0}, 32'h0);
    end
    chk("abort_mem7", tb_mem[7], 32'h0);
    chk("abort_rdata1", rdata1, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    @(negedge clock);
    chk("abort_idle_access", {31'h0, mem_read}, 32'h1);
    chk("abort_idle_noack", {31'h0, ack0}, 32'h0);
    @(negedge clock);
    chk("abort_idle_ack", {31'h0, ack0}, 32'h1);
    chk("abort_idle_rdata", rdata0, 32'h0);
    req0 = 1'b0;
    rd_model[0] = 32'h0; rd_model[1] = 32'h0;
    @(negedge clock);
    mon_en = 1; drv_en = 1;

    for (int i = 0; i < 4; i++) stim_q[0].push_back(mk(1'b1, 32'(i), 32'(i + 1)));
    run_phase("prewrite");
    for (int i = 0; i < 4; i++) stim_q[1].push_back(mk(1'b0, 32'(i), 32'h0));
    run_phase("port1_reads");

    gap_en = 1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(7, 0))
          0:       a = 32'd256 + 32'($urandom_range(767, 0));
          1:       a = $urandom;
          default: a = 32'($urandom_range(31, 0));
        endcase
        stim_q[p].push_back(mk(1'($urandom_range(1, 0)), a, $urandom));
      end
    end
    run_phase("random");

    mon_en = 0;
    for (int i = 0; i < 256; i++) chk("final_mem", tb_mem[i], ref_mem[i]);
    chk("write_count", wr_cnt, wr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
